// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared defaults, register address type and hazard helper for the scoreboard.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hazard_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW_DEF   = 5;

    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    // A source or destination conflicts with an in-flight result unless the
    // writeback of that very register is being bypassed in the same cycle.
    function automatic logic src_hazard(
        input logic valid,
        input logic used,
        input logic nonzero,
        input logic pend,
        input logic wb_hit
    );
        return valid && used && nonzero && pend && !wb_hit;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID/WB/branch bundle between the pipeline and the hazard scoreboard.
// Latency: none (wires only).
// Backpressure: stall is the only hold signal; pipeline owns the master side.
interface hazard_scoreboard_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 3
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_long_op;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              branch_taken;
    logic              stall;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic [CNT_W-1:0]  outstanding;
    logic              err_spurious_wb;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_long_op, wb_valid, wb_rd, branch_taken,
        input  stall, pc_write, if_id_write, if_id_flush, id_ex_flush,
               outstanding, err_spurious_wb
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_long_op, wb_valid, wb_rd, branch_taken,
        output stall, pc_write, if_id_write, if_id_flush, id_ex_flush,
               outstanding, err_spurious_wb
    );

endinterface

// File: rtl/hazard_scoreboard_unit_reg_pending_table.sv
// Per-register pending bits with set/clear ports; set wins over clear.
// Latency: updates on the next clk edge, lookups are combinational.
// Backpressure: none; callers decide when set/clear are legal.
module reg_pending_table
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              rd_pend,
    output logic              wb_pend
);

    logic [NUM_REGS-1:0] pending;

    // Addresses beyond the architectural file can never be pending.
    function automatic logic lookup(input logic [REG_AW-1:0] a);
        return (int'(a) < NUM_REGS) ? pending[a] : 1'b0;
    endfunction

    // Entry 0 is never written after reset, so x0 is never pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && int'(set_addr) == i)
                    pending[i] <= 1'b1;
                else if (clr_en && int'(clr_addr) == i)
                    pending[i] <= 1'b0;
            end
        end
    end

    // Combinational lookups for the ID sources, ID destination and WB target.
    always_comb begin
        rs1_pend = lookup(rs1);
        rs2_pend = lookup(rs2);
        rd_pend  = lookup(rd);
        wb_pend  = lookup(wb_rd);
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard unit: RAW/WAW/capacity interlock plus branch flush.
// Latency: stall/flush combinational; pending/count/error update next edge.
// Backpressure: stall holds PC and IF/ID; branch flush overrides stall.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int REG_AW          = REG_AW_DEF,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  bus
);

    logic             rs1_pend, rs2_pend, rd_pend, wb_pend;
    logic             src1_haz, src2_haz, waw_haz, cap_haz;
    logic             stall_int, issue, long_issue;
    logic             set_en, clr_en, wb_ok, wb_bad;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    reg_pending_table #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (bus.id_rd),
        .clr_en   (clr_en),
        .clr_addr (bus.wb_rd),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .rd       (bus.id_rd),
        .wb_rd    (bus.wb_rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .wb_pend  (wb_pend)
    );

    // Classify the completion, detect hazards and derive issue/set/clear.
    always_comb begin
        // A completion is honoured only if something is in flight and, for a
        // real register, that register is actually pending.
        wb_ok  = bus.wb_valid && (cnt_q != '0) && ((bus.wb_rd == '0) || wb_pend);
        wb_bad = bus.wb_valid && !wb_ok;
        clr_en = wb_ok && (bus.wb_rd != '0);

        src1_haz = src_hazard(bus.id_valid, bus.id_rs1_used, bus.id_rs1 != '0,
                              rs1_pend, bus.wb_valid && bus.wb_rd == bus.id_rs1);
        src2_haz = src_hazard(bus.id_valid, bus.id_rs2_used, bus.id_rs2 != '0,
                              rs2_pend, bus.wb_valid && bus.wb_rd == bus.id_rs2);
        waw_haz  = src_hazard(bus.id_valid, bus.id_rd_we, bus.id_rd != '0,
                              rd_pend, bus.wb_valid && bus.wb_rd == bus.id_rd);
        // A spurious completion frees no slot, so only an honoured one lifts
        // the capacity limit; this keeps the counter from overflowing.
        cap_haz  = bus.id_valid && bus.id_long_op &&
                   (cnt_q == CNT_W'(MAX_OUTSTANDING)) && !wb_ok;

        stall_int  = (src1_haz || src2_haz || waw_haz || cap_haz) && !bus.branch_taken;
        issue      = bus.id_valid && !stall_int && !bus.branch_taken;
        long_issue = issue && bus.id_long_op;
        set_en     = long_issue && bus.id_rd_we && (bus.id_rd != '0);
    end

    // Outstanding counter: issue and completion in the same cycle cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (long_issue && !wb_ok)
            cnt_q <= cnt_q + CNT_W'(1);
        else if (wb_ok && !long_issue)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    // Sticky error for completions that match nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (wb_bad)
            err_q <= 1'b1;
    end

    // Drive the pipeline control outputs.
    always_comb begin
        bus.stall           = stall_int;
        bus.pc_write        = !stall_int;
        bus.if_id_write     = !stall_int;
        bus.if_id_flush     = bus.branch_taken;
        bus.id_ex_flush     = bus.branch_taken;
        bus.outstanding     = cnt_q;
        bus.err_spurious_wb = err_q;
    end

endmodule
